lcd_ram_arbiter: RTL and testbench

- Shares the single write port of the 64-byte LCD display RAM between up to NREQ independent writers, e.g. the stopwatch digit updater, a static-text loader and a status/cursor writer.
- Each writer issues bursts of byte writes over a req/gnt handshake.
- The arbiter picks one owner round-robin, forwards its beats to the RAM write port and releases ownership at burst end.
- It sits between the writer processes and the RAM instance; the LCD12864 read side is untouched.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_ram_arbiter_if.sv | 30 +++
 rtl/lcd_ram_arbiter_rr_pick.sv | 31 +++
 rtl/lcd_ram_arbiter.sv | 111 +++++++++++
 tb/tb_lcd_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD display constants and the arbiter state type.
package lcd_pkg;

  localparam int LCD_AW    = 6;
  localparam int LCD_DW    = 8;
  localparam int LCD_CELLS = 64;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lcd_ram_arbiter_if.sv
// Writer-side burst bus plus the RAM write port driven by the arbiter.
interface lcd_ram_arbiter_if
  import lcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = LCD_AW,
  parameter int DW   = LCD_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    gnt;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_d;
  logic               busy;

  modport master (
    output req, addr, wdata, last,
    input  gnt, ram_we, ram_addr, ram_d, busy
  );

  modport slave (
    input  req, addr, wdata, last,
    output gnt, ram_we, ram_addr, ram_d, busy
  );

endinterface

// File: rtl/lcd_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after i_rr_ptr.
// With LCD_RAM_ARB_PRIO0_EN defined, requester 0 wins whenever it requests.
module lcd_ram_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_sel,
  output logic [PW-1:0]   o_sel_idx,
  output logic            o_any
);

  always_comb begin
    int idx;
    o_sel     = '0;
    o_sel_idx = '0;
    o_any     = |i_req;
    idx       = 0;
    // Scan farthest-first so the requester nearest the pointer is assigned last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(i_rr_ptr) + k) % NREQ;
      if (i_req[idx]) o_sel_idx = PW'(idx);
    end
`ifdef LCD_RAM_ARB_PRIO0_EN
    if (i_req[0]) o_sel_idx = '0;
`endif
    if (o_any) o_sel[o_sel_idx] = 1'b1;
  end

endmodule

// File: rtl/lcd_ram_arbiter.sv
// Round-robin burst arbiter for the LCD display RAM write port.
// Optional LCD_RAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module lcd_ram_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = LCD_AW,
  parameter int DW        = LCD_DW,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  lcd_ram_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  arb_state_e      r_state, w_state_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]   w_sel_idx, w_owner_inc;
  logic [NREQ-1:0] r_owner_oh, w_owner_oh_nxt, w_sel;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic            w_any, w_xfer, w_release;
  logic            r_ram_we;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_d;

  lcd_ram_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req     (bus.req),
    .i_rr_ptr  (r_rr_ptr),
    .o_sel     (w_sel),
    .o_sel_idx (w_sel_idx),
    .o_any     (w_any)
  );

  assign w_xfer      = (r_state == ARB_BURST) && bus.req[r_owner];
  assign w_owner_inc = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_owner_oh_nxt = r_owner_oh;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_release      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt    = ARB_BURST;
          w_owner_nxt    = w_sel_idx;
          w_owner_oh_nxt = w_sel;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_BURST: begin
        // A dropped req abandons the burst; no beat moves that cycle.
        if (!w_xfer) begin
          w_release = 1'b1;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (bus.last[r_owner] || (r_beat_cnt == LAST_CNT)) w_release = 1'b1;
        end
        if (w_release) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
`ifdef LCD_RAM_ARB_PRIO0_EN
          if (r_owner == '0) w_rr_ptr_nxt = r_rr_ptr;
`endif
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_d    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_oh <= w_owner_oh_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_ram_we   <= w_xfer;
      if (w_xfer) begin
        r_ram_addr <= bus.addr[r_owner*AW +: AW];
        r_ram_d    <= bus.wdata[r_owner*DW +: DW];
      end
    end
  end

  assign bus.gnt      = (r_state == ARB_BURST) ? (bus.req & r_owner_oh) : '0;
  assign bus.busy     = (r_state == ARB_BURST);
  assign bus.ram_we   = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_d    = r_ram_d;

endmodule

// File: tb/tb_lcd_ram_arbiter.sv
// Bench for lcd_ram_arbiter: vector table, directed corner cases, random traffic vs. model.
module tb_lcd_ram_arbiter;
  import lcd_pkg::*;

  localparam int NREQ      = 4;
  localparam int AW        = 6;
  localparam int DW        = 8;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  lcd_ram_arbiter #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port, beats taken, next fair start point.
  int            m_owner;
  int            m_beats;
  int            m_rr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d;

  logic [NREQ-1:0] s_gnt;
  logic            s_busy;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_d;
  } vec_t;

  vec_t tbl[10];
  logic we_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef LCD_RAM_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_gnt();
    if (m_owner >= 0 && bus.req[m_owner]) return NREQ'(1) << m_owner;
    return '0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_rr    = 0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_d     = '0;
  endtask

  task automatic model_release();
`ifdef LCD_RAM_ARB_PRIO0_EN
    if (m_owner != 0) m_rr = (m_owner + 1) % NREQ;
`else
    m_rr = (m_owner + 1) % NREQ;
`endif
    m_owner = -1;
  endtask

  task automatic model_step();
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      m_we = 1'b0;
      p = pick(bus.req, m_rr);
      if (p >= 0) begin
        m_owner = p;
        m_beats = 0;
      end
    end else if (bus.req[m_owner]) begin
      m_we   = 1'b1;
      m_addr = bus.addr[m_owner*AW +: AW];
      m_d    = bus.wdata[m_owner*DW +: DW];
      m_beats++;
      if (bus.last[m_owner] || m_beats == MAX_BURST) model_release();
    end else begin
      m_we = 1'b0;
      model_release();
    end
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    #1;
    s_gnt  = bus.gnt;
    s_busy = bus.busy;
    check("gnt", 32'(bus.gnt), 32'(model_gnt()));
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'(1));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    model_step();
    @(posedge clk);
    #1;
    check("ram_we", 32'(bus.ram_we), 32'(m_we));
    check("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    check("ram_d", 32'(bus.ram_d), 32'(m_d));
  endtask

  task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
    bus.last[i]           = l;
  endtask

  task automatic run_beats(input int who, input int n, input int base, output int got);
    got = 0;
    bus.req = NREQ'(1) << who;
    for (int c = 0; c < n + 8; c++) begin
      drive(who, AW'(base + got), DW'(base + got), 1'b0);
      tick();
      if (s_gnt[who]) got++;
      if (got == n) break;
    end
    check("beats_taken", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    int first, run1, gap, run2, idx;

    tbl[0] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 6'h00, 8'h00};
    tbl[1] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 6'h20, ASCII_ZERO};
    tbl[2] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 6'h20, ASCII_ZERO};
    tbl[3] = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 6'h21, ASCII_ZERO + 8'd1};
    tbl[4] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 6'h21, ASCII_ZERO + 8'd1};
    tbl[5] = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 6'h22, ASCII_ZERO + 8'd2};
    tbl[6] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 6'h22, ASCII_ZERO + 8'd2};
    tbl[7] = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 6'h23, ASCII_ZERO + 8'd3};
    tbl[8] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 6'h23, ASCII_ZERO + 8'd3};
    tbl[9] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 6'h20, ASCII_ZERO};

    // Reset held with every requester asking
    rst_n     = 1'b0;
    bus.req   = 4'b1111;
    bus.last  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_we", 32'(bus.ram_we), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) drive(i, AW'(32'h20 + i), ASCII_ZERO + DW'(i), 1'b1);

    // Round-robin over single-beat bursts
    for (int v = 0; v < 10; v++) begin
      bus.req  = tbl[v].req;
      bus.last = tbl[v].last;
      tick();
      check($sformatf("tbl%0d_gnt", v), 32'(s_gnt), 32'(tbl[v].exp_gnt));
      check($sformatf("tbl%0d_we", v), 32'(bus.ram_we), 32'(tbl[v].exp_we));
      check($sformatf("tbl%0d_addr", v), 32'(bus.ram_addr), 32'(tbl[v].exp_addr));
      check($sformatf("tbl%0d_d", v), 32'(bus.ram_d), 32'(tbl[v].exp_d));
    end

    // Three-beat burst from requester 2
    bus.req  = 4'b0100;
    bus.last = '0;
    drive(2, 6'h10, 8'h41, 1'b0);
    tick();
    check("sb_idle_gnt", 32'(s_gnt), 32'(0));
    tick();
    check("sb_gnt", 32'(s_gnt), 32'(4'b0100));
    check("sb_b0", {bus.ram_we, 9'd0, bus.ram_addr, 8'd0, bus.ram_d}, {1'b1, 9'd0, 6'h10, 8'd0, 8'h41});
    drive(2, 6'h11, 8'h42, 1'b0);
    tick();
    check("sb_b1", {bus.ram_we, 9'd0, bus.ram_addr, 8'd0, bus.ram_d}, {1'b1, 9'd0, 6'h11, 8'd0, 8'h42});
    drive(2, 6'h12, 8'h43, 1'b1);
    tick();
    check("sb_b2", {bus.ram_we, 9'd0, bus.ram_addr, 8'd0, bus.ram_d}, {1'b1, 9'd0, 6'h12, 8'd0, 8'h43});
    check("sb_busy_after", 32'(bus.busy), 32'(0));
    bus.req  = '0;
    bus.last = '0;
    tick();
    check("sb_we_after", 32'(bus.ram_we), 32'(0));
    // Pointer now at 3: full request must go to requester 3
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    tick();
    tick();
    check("rr_after_sb", 32'(s_gnt), 32'(4'b1000));
    bus.req  = '0;
    bus.last = '0;
    tick();

    // Forced release after MAX_BURST beats
    we_hist.delete();
    got = 0;
    bus.req = 4'b0010;
    for (int c = 0; c < 60; c++) begin
      drive(1, AW'(got), DW'(got), 1'b0);
      tick();
      we_hist.push_back(bus.ram_we);
      if (s_gnt[1]) got++;
      if (got == 20) break;
    end
    bus.req = '0;
    tick();
    we_hist.push_back(bus.ram_we);
    first = -1;
    foreach (we_hist[i]) if (first < 0 && we_hist[i]) first = i;
    run1 = 0; gap = 0; run2 = 0;
    idx = (first < 0) ? we_hist.size() : first;
    while (idx < we_hist.size() && we_hist[idx]) begin run1++; idx++; end
    while (idx < we_hist.size() && !we_hist[idx]) begin gap++; idx++; end
    while (idx < we_hist.size() && we_hist[idx]) begin run2++; idx++; end
    check("fr_total", 32'(got), 32'(20));
    check("fr_run1", 32'(run1), 32'(16));
    check("fr_gap", 32'(gap), 32'(1));
    check("fr_run2", 32'(run2), 32'(4));

    // Abandoned burst
    run_beats(3, 2, 8, got);
    bus.req = '0;
    tick();
    check("ab_we", 32'(bus.ram_we), 32'(0));
    check("ab_busy", 32'(bus.busy), 32'(0));
    tick();

    // Reset during beat 5
    run_beats(1, 4, 48, got);
    drive(1, 6'h35, 8'h35, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_we", 32'(bus.ram_we), 32'(0));
    check("mr_gnt", 32'(bus.gnt), 32'(0));
    check("mr_busy", 32'(bus.busy), 32'(0));
    check("mr_addr", 32'(bus.ram_addr), 32'(0));
    model_reset();
    tick();
    check("mr_nowrite", 32'(bus.ram_we), 32'(0));
    rst_n   = 1'b1;
    bus.req = '0;
    tick();

    // Priority of requester 0 with pointer parked at 2
    bus.req  = 4'b0010;
    bus.last = 4'b0010;
    tick();
    tick();
    bus.req  = 4'b0101;
    bus.last = 4'b0101;
    tick();
    tick();
`ifdef LCD_RAM_ARB_PRIO0_EN
    check("prio_first", 32'(s_gnt), 32'(4'b0001));
`else
    check("prio_first", 32'(s_gnt), 32'(4'b0100));
`endif
    bus.req  = '0;
    bus.last = '0;
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req   = NREQ'($urandom) | NREQ'($urandom);
      bus.last  = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      bus.addr  = (NREQ*AW)'($urandom);
      bus.wdata = (NREQ*DW)'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
